// File: rtl/hazard_controller_pkg.sv
// Shared constants, stage-record layout and forwarding helpers for the
// hazard controller.
//
// Contents:
//   REC_AW          register index width carried in each stage record
//   CNT_W           width of the load-use stall counter (LOAD_LAT up to 7)
//   FWD_NONE/MEM/WB ALU operand source selects
//   stage_rec_t     {vld, rd, we, m2r, rs1, rs2} shadow record of one stage
//   producer_hits() does a producer record supply a given source register
//   fwd_select()    operand source select for one source of a consumer
package hazard_controller_pkg;

    localparam int REC_AW = 5;
    localparam int CNT_W  = 3;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    typedef struct packed {
        logic              vld;
        logic [REC_AW-1:0] rd;
        logic              we;
        logic              m2r;
        logic [REC_AW-1:0] rs1;
        logic [REC_AW-1:0] rs2;
    } stage_rec_t;

    localparam int REC_W = $bits(stage_rec_t);

    // A bubble is an all-zero record; with vld = 0 it can neither stall nor forward.
    localparam stage_rec_t BUBBLE_REC = stage_rec_t'({REC_W{1'b0}});

    // True when producer p writes a nonzero register equal to src.
    // allow_load = 0 excludes loads, whose data is not yet available in M.
    function automatic logic producer_hits(
        input stage_rec_t        p,
        input logic [REC_AW-1:0] src,
        input logic              allow_load
    );
        return p.vld & p.we & (p.rd != {REC_AW{1'b0}}) & (p.rd == src)
               & (allow_load | ~p.m2r);
    endfunction

    // Operand select for one source of the consumer; M (youngest) wins over W.
    function automatic logic [1:0] fwd_select(
        input stage_rec_t cons,
        input stage_rec_t m,
        input stage_rec_t w,
        input logic       use_rs2
    );
        logic [REC_AW-1:0] src;
        logic [1:0]        sel;
        src = use_rs2 ? cons.rs2 : cons.rs1;
        if (!cons.vld) begin
            sel = FWD_NONE;
        end else if (producer_hits(m, src, 1'b0)) begin
            sel = FWD_MEM;
        end else if (producer_hits(w, src, 1'b1)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_controller_stage_rec.sv
// hazard_stage_rec: one pipeline-stage shadow record register.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset, clears the record
//   hold    in   keep the current record
//   bubble  in   load an empty record (vld = 0); takes priority over hold
//   d       in   next record when neither bubble nor hold
//   q       out  current record
module hazard_stage_rec
    import hazard_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             bubble,
    input  logic [REC_W-1:0] d,
    output logic [REC_W-1:0] q
);

    // Record register: killing an instruction beats freezing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {REC_W{1'b0}};
        end else if (bubble) begin
            q <= BUBBLE_REC;
        end else if (hold) begin
            q <= q;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall, flush and forwarding control for a 5-stage core.
// Tracks register indices and write controls of the instructions in E, M
// and W; never sees data values.
//
// Parameters:
//   REG_AW    register index width (must match the package record width)
//   LOAD_LAT  load-use stall length in cycles, 1..7
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid                  decode holds a real instruction
//   id_rs1, id_rs2, id_rd     decode register indices
//   id_de_we, id_mem_to_reg   decode write / load controls
//   id_brn_cond               decode conditional branch (ordinary consumer)
//   ex_brn_taken              branch in E resolved taken
//   STALL_F, STALL_D          hold PC / F-D register (combinational)
//   FLUSH_D, FLUSH_E          kill F-D / bubble into D-E (combinational)
//   FWD_A_SEL, FWD_B_SEL      operand sources for E (registered)
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int REG_AW   = REC_AW,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_de_we,
    input  logic              id_mem_to_reg,
    input  logic              id_brn_cond,
    input  logic              ex_brn_taken,
    output logic              STALL_F,
    output logic              STALL_D,
    output logic              FLUSH_D,
    output logic              FLUSH_E,
    output logic [1:0]        FWD_A_SEL,
    output logic [1:0]        FWD_B_SEL
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(LOAD_LAT - 1);

    logic [REC_W-1:0] e_q_s;
    logic [REC_W-1:0] m_q_s;
    logic [REC_W-1:0] w_q_s;
    stage_rec_t       e_rec_s;
    stage_rec_t       m_rec_s;
    stage_rec_t       w_rec_s;
    stage_rec_t       id_rec_s;
    stage_rec_t       e_next_s;

    logic             load_use_s;
    logic             stall_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [1:0]       fwd_a_r;
    logic [1:0]       fwd_b_r;

    // Branches compare in E, so in decode they are plain rs1/rs2 consumers.
    logic             brn_cond_unused_s;
    assign brn_cond_unused_s = id_brn_cond;

    assign e_rec_s = stage_rec_t'(e_q_s);
    assign m_rec_s = stage_rec_t'(m_q_s);
    assign w_rec_s = stage_rec_t'(w_q_s);

    // Pack the decode-stage controls into a record headed for E.
    always_comb begin
        id_rec_s     = BUBBLE_REC;
        id_rec_s.vld = id_valid;
        id_rec_s.rd  = id_rd;
        id_rec_s.we  = id_de_we;
        id_rec_s.m2r = id_mem_to_reg;
        id_rec_s.rs1 = id_rs1;
        id_rec_s.rs2 = id_rs2;
    end

    // A load in E whose nonzero destination is read by the decode instruction.
    always_comb begin
        load_use_s = e_rec_s.vld & e_rec_s.m2r & (e_rec_s.rd != {REC_AW{1'b0}})
                     & id_valid & ((id_rs1 == e_rec_s.rd) | (id_rs2 == e_rec_s.rd));
    end

    // Stall/flush decision; branch beats an active or new load-use stall.
    always_comb begin
        stall_s    = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        cnt_next_s = cnt_r;
        if (rst) begin
            cnt_next_s = CNT_ZERO;
        end else if (ex_brn_taken) begin
            flush_d_s  = 1'b1;
            flush_e_s  = 1'b1;
            cnt_next_s = CNT_ZERO;
        end else if (cnt_r != CNT_ZERO) begin
            // Remaining cycles of a load-use stall; hazard input is ignored.
            stall_s    = 1'b1;
            flush_e_s  = 1'b1;
            cnt_next_s = cnt_r - CNT_ONE;
        end else if (load_use_s) begin
            // First stall cycle; LOAD_LAT-1 more follow from the counter.
            stall_s    = 1'b1;
            flush_e_s  = 1'b1;
            cnt_next_s = LAT_M1;
        end else begin
            cnt_next_s = CNT_ZERO;
        end
    end

    // Record that E will hold after this edge.
    always_comb begin
        if (flush_e_s) begin
            e_next_s = BUBBLE_REC;
        end else begin
            e_next_s = id_rec_s;
        end
    end

    // Load-use stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // Forwarding selects from the next E/M/W records, so they line up with E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_r <= FWD_NONE;
            fwd_b_r <= FWD_NONE;
        end else begin
            fwd_a_r <= fwd_select(e_next_s, e_rec_s, m_rec_s, 1'b0);
            fwd_b_r <= fwd_select(e_next_s, e_rec_s, m_rec_s, 1'b1);
        end
    end

    hazard_stage_rec u_rec_e (
        .clk    (clk),
        .rst    (rst),
        .hold   (1'b0),
        .bubble (flush_e_s),
        .d      (id_rec_s),
        .q      (e_q_s)
    );

    hazard_stage_rec u_rec_m (
        .clk    (clk),
        .rst    (rst),
        .hold   (1'b0),
        .bubble (1'b0),
        .d      (e_q_s),
        .q      (m_q_s)
    );

    hazard_stage_rec u_rec_w (
        .clk    (clk),
        .rst    (rst),
        .hold   (1'b0),
        .bubble (1'b0),
        .d      (m_q_s),
        .q      (w_q_s)
    );

    assign STALL_F   = stall_s;
    assign STALL_D   = stall_s;
    assign FLUSH_D   = flush_d_s;
    assign FLUSH_E   = flush_e_s;
    assign FWD_A_SEL = fwd_a_r;
    assign FWD_B_SEL = fwd_b_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: one instance with LOAD_LAT = 1 and one
// with LOAD_LAT = 3 driven by the same decode-stage stimulus.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_de_we;
    logic       id_mem_to_reg;
    logic       id_brn_cond;
    logic       ex_brn_taken;

    logic       sf1, sd1, fd1, fe1;
    logic [1:0] fa1, fb1;
    logic       sf3, sd3, fd3, fe3;
    logic [1:0] fa3, fb3;

    logic [3:0] ctl1;
    logic [3:0] ctl3;
    assign ctl1 = {sf1, sd1, fd1, fe1};
    assign ctl3 = {sf3, sd3, fd3, fe3};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_AW(5), .LOAD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_de_we(id_de_we), .id_mem_to_reg(id_mem_to_reg),
        .id_brn_cond(id_brn_cond), .ex_brn_taken(ex_brn_taken),
        .STALL_F(sf1), .STALL_D(sd1), .FLUSH_D(fd1), .FLUSH_E(fe1),
        .FWD_A_SEL(fa1), .FWD_B_SEL(fb1)
    );

    hazard_controller #(.REG_AW(5), .LOAD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_de_we(id_de_we), .id_mem_to_reg(id_mem_to_reg),
        .id_brn_cond(id_brn_cond), .ex_brn_taken(ex_brn_taken),
        .STALL_F(sf3), .STALL_D(sd3), .FLUSH_D(fd3), .FLUSH_E(fe3),
        .FWD_A_SEL(fa3), .FWD_B_SEL(fb3)
    );

    // Control vector order: {STALL_F, STALL_D, FLUSH_D, FLUSH_E}
    localparam logic [3:0] C_IDLE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1101;
    localparam logic [3:0] C_BRN   = 4'b0011;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic m2r);
        id_valid      = v;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_rd         = rd;
        id_de_we      = we;
        id_mem_to_reg = m2r;
        id_brn_cond   = 1'b0;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        nop();
        ex_brn_taken = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        // Reset: outputs quiet even with a taken branch and a load-like decode.
        drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
        ex_brn_taken = 1'b1;
        #2;
        chk("reset_ctl1", ctl1, C_IDLE);
        chk("reset_ctl3", ctl3, C_IDLE);
        chk("reset_fwd_a", {2'b00, fa1}, {2'b00, FWD_NONE});
        chk("reset_fwd_b", {2'b00, fb1}, {2'b00, FWD_NONE});
        ex_brn_taken = 1'b0;
        nop();
        rst = 1'b0;
        next_cycle();

        // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); #1;
        chk("t2_add_ctl", ctl1, C_IDLE);
        next_cycle();
        drive(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0); #1;
        chk("t2_sub_ctl", ctl1, C_IDLE);
        next_cycle();
        nop(); #1;
        chk("t2_fwd_a_mem", {2'b00, fa1}, {2'b00, FWD_MEM});
        chk("t2_fwd_b_none", {2'b00, fb1}, {2'b00, FWD_NONE});
        drain(3);

        // add x5 ; nop ; sub x6,x5,x3 -> WB forward
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); next_cycle();
        nop(); next_cycle();
        drive(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0); next_cycle();
        nop(); #1;
        chk("t2_fwd_a_wb", {2'b00, fa1}, {2'b00, FWD_WB});
        drain(3);

        // addi x4 ; addi x4 ; add x9,x4,x0 -> youngest (MEM) wins, x0 never forwards
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0); next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0); next_cycle();
        drive(1'b1, 5'd4, 5'd0, 5'd9, 1'b1, 1'b0); next_cycle();
        nop(); #1;
        chk("t6_fwd_a_young", {2'b00, fa1}, {2'b00, FWD_MEM});
        chk("t6_fwd_b_x0", {2'b00, fb1}, {2'b00, FWD_NONE});
        drain(3);

        // lw x7,0(x1) ; add x8,x7,x7 : 1 stall cycle (LAT 1), 3 stall cycles (LAT 3)
        drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1); #1;
        chk("t3_lw_ctl1", ctl1, C_IDLE);
        next_cycle();
        drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0); #1;
        chk("t3_c1_ctl1", ctl1, C_STALL);
        chk("t3_c1_ctl3", ctl3, C_STALL);
        next_cycle(); #1;
        chk("t3_c2_ctl1", ctl1, C_IDLE);
        chk("t3_c2_ctl3", ctl3, C_STALL);
        next_cycle(); #1;
        chk("t3_c3_ctl1", ctl1, C_IDLE);
        chk("t3_c3_ctl3", ctl3, C_STALL);
        chk("t3_fwd_a_wb", {2'b00, fa1}, {2'b00, FWD_WB});
        chk("t3_fwd_b_wb", {2'b00, fb1}, {2'b00, FWD_WB});
        next_cycle(); #1;
        chk("t3_c4_ctl3", ctl3, C_IDLE);
        nop();
        next_cycle(); #1;
        chk("t3_c5_fwd3_a", {2'b00, fa3}, {2'b00, FWD_NONE});
        drain(4);

        // lw x0,0(x1) ; add x2,x0,x0 -> no stall, no forward
        drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1); next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0); #1;
        chk("t4_ctl1", ctl1, C_IDLE);
        chk("t4_ctl3", ctl3, C_IDLE);
        next_cycle();
        nop(); #1;
        chk("t4_fwd_a", {2'b00, fa1}, {2'b00, FWD_NONE});
        chk("t4_fwd_b", {2'b00, fb1}, {2'b00, FWD_NONE});
        drain(4);

        // Branch taken during a pending load-use stall (LAT 3 counter = 2)
        drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1); next_cycle();
        drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0); #1;
        chk("t5_c1_ctl3", ctl3, C_STALL);
        next_cycle();
        ex_brn_taken = 1'b1; #1;
        chk("t5_brn_ctl3", ctl3, C_BRN);
        chk("t5_brn_ctl1", ctl1, C_BRN);
        next_cycle();
        ex_brn_taken = 1'b0;
        nop(); #1;
        chk("t5_after_ctl3", ctl3, C_IDLE);
        drain(4);

        // Branch beats a fresh load-use hazard
        drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1); next_cycle();
        drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
        ex_brn_taken = 1'b1; #1;
        chk("t5_prio_ctl1", ctl1, C_BRN);
        chk("t5_prio_ctl3", ctl3, C_BRN);
        next_cycle();
        ex_brn_taken = 1'b0;
        nop(); #1;
        chk("t5_prio_after3", ctl3, C_IDLE);
        drain(4);

        // Reset mid-stall with forwarding active
        drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1); next_cycle();
        drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0); next_cycle();
        next_cycle(); #1;
        chk("t1_pre_ctl3", ctl3, C_STALL);
        chk("t1_pre_fwd_a", {2'b00, fa1}, {2'b00, FWD_WB});
        ex_brn_taken = 1'b1;
        rst = 1'b1; #1;
        chk("t1_rst_ctl1", ctl1, C_IDLE);
        chk("t1_rst_ctl3", ctl3, C_IDLE);
        chk("t1_rst_fwd_a", {2'b00, fa1}, {2'b00, FWD_NONE});
        chk("t1_rst_fwd_b", {2'b00, fb1}, {2'b00, FWD_NONE});
        rst = 1'b0;
        ex_brn_taken = 1'b0;
        next_cycle(); #1;
        chk("t1_post_ctl3", ctl3, C_IDLE);
        chk("t1_post_ctl1", ctl1, C_IDLE);
        nop();
        next_cycle(); #1;
        chk("t1_post_fwd_a", {2'b00, fa1}, {2'b00, FWD_NONE});
        drain(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
